// File: rtl/mem_access_unit.sv
`default_nettype none
//============================================================================
// Module      : mem_access_unit
// Description : Memory-stage unit. Turns MemRead_M/MemWrite_M into a
//               req/gnt/rvalid transaction on a multi-cycle data-memory port,
//               stalls the pipeline until the access completes (or times out)
//               and resolves the branch select PCSrc_M.
//               Optional feature macro: MEM_ALIGN_CHECK_EN (rejects accesses
//               whose address is not 8-byte aligned, pulsing misalign_M).
// Revision    : 1.0 - initial release
//============================================================================
module mem_access_unit #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_O,
    output logic         stall_M,
    output logic [N-1:0] readData_M,
    output logic         bus_err_M,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic         misalign_M
);

    // Counter only has to hold 0..TIMEOUT-1.
    localparam int              c_CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REQ    = 2'd1;
    localparam logic [1:0] c_WAIT_R = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_req;
    logic            r_we;
    logic [N-1:0]    r_addr;
    logic [N-1:0]    r_wdata;
    logic [N-1:0]    r_rdata;
    logic            r_bus_err;
    logic            r_misalign;

    logic            w_acc;
    logic            w_misalign;
    logic            w_cnt_exp;

    assign w_acc     = MemRead_M | MemWrite_M;
    assign w_cnt_exp = (r_cnt == c_CNT_MAX);

`ifdef MEM_ALIGN_CHECK_EN
    // An access to a non-doubleword-aligned address is rejected in IDLE.
    assign w_misalign = w_acc & (aluResult_M[2:0] != 3'b000);
`else
    assign w_misalign = 1'b0;
`endif

    // Branch resolution is purely combinational and FSM-independent.
    assign PCSrc_M    = Branch_M & zero_M;
    assign PCBranch_O = PCBranch_M;

    // Hold upstream while an access is being launched or is outstanding.
    assign stall_M = ((r_state == c_IDLE) & w_acc)
                   | (r_state == c_REQ)
                   | (r_state == c_WAIT_R);

    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign readData_M = r_rdata;
    assign bus_err_M  = r_bus_err;
    assign misalign_M = r_misalign;

    // Access FSM with per-phase timeout; inputs are only sampled in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_bus_err  <= 1'b0;
                    r_misalign <= 1'b0;
                    if (w_misalign) begin
                        // Rejected access: no bus cycle, loads return zero.
                        r_misalign <= 1'b1;
                        if (!MemWrite_M) begin
                            r_rdata <= '0;
                        end
                        r_state <= c_DONE;
                    end else if (w_acc) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_M;
                        r_addr  <= aluResult_M;
                        r_wdata <= writeData_M;
                        r_cnt   <= '0;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (mem_gnt) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_state <= c_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= c_WAIT_R;
                        end
                    end else if (w_cnt_exp) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_WAIT_R: begin
                    if (mem_rvalid) begin
                        r_rdata <= mem_rdata;
                        r_state <= c_DONE;
                    end else if (w_cnt_exp) begin
                        r_rdata   <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    // DONE: single cycle in which the pipeline advances.
                    r_bus_err  <= 1'b0;
                    r_misalign <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Accesses are driven
//               one at a time; a transaction-level model predicts stall
//               length, bus phases, load data, bus error and misalign.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_access_unit;

    localparam int N  = 64;
    localparam int TO = 4;

    logic         clk;
    logic         reset;
    logic         MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
    logic         PCSrc_M;
    logic [N-1:0] PCBranch_O;
    logic         stall_M;
    logic [N-1:0] readData_M;
    logic         bus_err_M;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_gnt, mem_rvalid;
    logic [N-1:0] mem_rdata;
    logic         misalign_M;

    int n_total = 0;
    int n_bad   = 0;
    logic [N-1:0] model_rd = '0;

    mem_access_unit #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .Branch_M(Branch_M), .zero_M(zero_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M),
        .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .PCBranch_O(PCBranch_O),
        .stall_M(stall_M), .readData_M(readData_M), .bus_err_M(bus_err_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .misalign_M(misalign_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One instruction through the memory stage. g = REQ cycles without gnt
    // before gnt appears, r = WAIT_R cycles without rvalid before rvalid.
    task automatic run_access(input bit rd, input bit wr, input logic [N-1:0] addr,
                              input logic [N-1:0] wdata, input logic [N-1:0] rdata,
                              input int g, input int r, input bit br, input bit zf,
                              input logic [N-1:0] pcb);
        bit acc, is_w, mis, gnt_ok, rv_ok, exp_err;
        int exp_req, exp_wait, stalls, reqc, waitc, cyc;
        bit first;
        acc  = rd | wr;
        is_w = wr;
        mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis  = acc && (addr[2:0] != 3'b000);
`endif
        gnt_ok   = (g < TO);
        rv_ok    = (r < TO);
        exp_req  = (!acc || mis) ? 0 : (gnt_ok ? g + 1 : TO);
        exp_wait = (!acc || mis || is_w || !gnt_ok) ? 0 : (rv_ok ? r + 1 : TO);
        exp_err  = acc && !mis && (!gnt_ok || (!is_w && !rv_ok));
        if (acc && !is_w) begin
            if (mis || !gnt_ok || !rv_ok) model_rd = '0;
            else                          model_rd = rdata;
        end

        @(negedge clk);
        MemRead_M = rd; MemWrite_M = wr; aluResult_M = addr; writeData_M = wdata;
        Branch_M = br; zero_M = zf; PCBranch_M = pcb;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        stalls = 0; reqc = 0; waitc = 0; cyc = 0; first = 1'b1;
        while (stall_M && cyc < 64) begin
            stalls++;
            if (first) begin
                first = 1'b0;
            end else if (mem_req) begin
                if (reqc == 0) begin
                    chk("req_we", {63'd0, mem_we}, {63'd0, is_w});
                    chk("req_addr", mem_addr, addr);
                    if (is_w) chk("req_wdata", mem_wdata, wdata);
                end
                mem_gnt = (reqc == g);
                reqc++;
            end else begin
                mem_rvalid = (waitc == r);
                mem_rdata  = rdata;
                waitc++;
            end
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            cyc++;
        end
        if (cyc >= 64) chk("stall_bound", 64'd1, 64'd0);
        // Now in DONE (or still IDLE for a non-memory instruction).
        chk("stall_cycles", 64'(stalls), 64'(acc ? 1 + exp_req + exp_wait : 0));
        chk("req_cycles", 64'(reqc), 64'(exp_req));
        chk("wait_cycles", 64'(waitc), 64'(exp_wait));
        chk("done_req", {63'd0, mem_req}, 64'd0);
        chk("bus_err", {63'd0, bus_err_M}, {63'd0, exp_err});
        chk("misalign", {63'd0, misalign_M}, {63'd0, mis});
        chk("readData", readData_M, model_rd);
        chk("pcsrc", {63'd0, PCSrc_M}, {63'd0, br & zf});
        chk("pcbranch", PCBranch_O, pcb);
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        if (acc) begin
            // Pulses last exactly one cycle.
            @(negedge clk); #1;
            chk("err_pulse", {63'd0, bus_err_M}, 64'd0);
            chk("stall_after", {63'd0, stall_M}, 64'd0);
        end
    endtask

    initial begin
        MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
        aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_rd", readData_M, 64'd0);
        chk("rst_stall", {63'd0, stall_M}, 64'd0);
        reset = 1'b1;

        // Directed scenarios.
        run_access(0, 1, 64'h40, 64'hDEAD, 64'h0, 0, 0, 0, 0, 64'h0);
        run_access(1, 0, 64'h80, 64'h0, 64'h1234, 2, 2, 0, 0, 64'h0);
        run_access(1, 0, 64'h88, 64'h0, 64'h5555, 99, 0, 0, 0, 64'h0);
        run_access(0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 1, 1, 64'h100);
        run_access(1, 0, 64'h90, 64'h0, 64'h7777, 0, 99, 1, 0, 64'h8);
        run_access(0, 1, 64'h98, 64'h1, 64'h0, 99, 0, 0, 1, 64'h0);
        run_access(1, 1, 64'hA0, 64'h2, 64'h3333, 3, 0, 0, 0, 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int op;
            logic [N-1:0] a;
            op = int'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            run_access(op == 1 || op == 3, op == 2 || op == 3, a,
                       {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)),
                       1'($urandom), 1'($urandom), {$urandom, $urandom});
        end

        // Load that leaves non-zero data, then reset in the middle of WAIT_R.
        run_access(1, 0, 64'hC0, 64'h0, 64'hCAFE, 0, 0, 0, 0, 64'h0);
        @(negedge clk);
        MemRead_M = 1'b1; aluResult_M = 64'hC8;
        @(negedge clk);            // REQ
        mem_gnt = 1'b1;
        @(negedge clk);            // WAIT_R
        mem_gnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
        chk("mid_rst_rd", readData_M, 64'd0);
        MemRead_M = 1'b0;
        #1;
        chk("mid_rst_idle", {63'd0, stall_M}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late_rvalid_rd", readData_M, 64'd0);
        chk("late_rvalid_stall", {63'd0, stall_M}, 64'd0);
        model_rd = '0;
        run_access(1, 0, 64'hD0, 64'h0, 64'h4242, 1, 1, 0, 0, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
